uart_tx_ctrl: RTL
=================

Name: uart_tx_ctrl

Overview:
- UART transmit sequencer around a parallel-in/serial-out shift path.
- Accepts a WIDTH-bit word on a valid/ready handshake and generates bit timing from a clock divider.
- Frames the word as start bit, data LSB-first, then stop bit, and drives the serial line.
- Sits between the byte source (host/FIFO) and the UART TX pin; it is the block that loads and shifts the serializer.

Parameters:
- WIDTH, 8, data bits per frame.
- CLK_DIV, 4, clk cycles per bit period; legal range 2..65535.
- PARITY_ODD, 0, parity sense when parity is compiled in: 0 = even, 1 = odd. Ignored otherwise.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- data  input  WIDTH  word to transmit; sampled only on accept.
- valid  input  1  source has a word on data.
- ready  output  1  controller can accept a word this cycle.
- tx  output  1  serial line; idle high.
- busy  output  1  a frame is in progress.

Behaviour:
- Clocking and reset:
  - One clock, clk.
  - Reset is synchronous and active-high on port reset, sampled on the clk rising edge.
  - On reset: tx=1, ready=1, busy=0, state=IDLE, baud counter=0, bit counter=0, shift register=0.
- States: IDLE, START, DATA, STOP (plus PARITY when compiled in).
- IDLE:
  - ready=1, busy=0, tx=1.
  - Accept occurs on a rising edge with valid=1 and ready=1.
  - On accept: latch data into the shift register, go to START, clear the baud counter.
- Bit timing:
  - Each non-IDLE state holds tx stable for exactly CLK_DIV cycles.
  - Baud counter runs 0..CLK_DIV-1; the state advances when the counter reaches CLK_DIV-1.
- START: tx=0, ready=0, busy=1. The first cycle of START is the cycle after accept (latency 1).
- DATA:
  - tx = shift register bit 0.
  - At each bit end: shift right by one and increment the bit counter.
  - After WIDTH bits, go to STOP (or PARITY).
- STOP: tx=1 for CLK_DIV cycles, then IDLE.
- Frame length: (WIDTH+2)*CLK_DIV cycles from the first START cycle to the last STOP cycle.
- Back-to-back: ready is asserted only in IDLE. With valid held high continuously, there is exactly one IDLE cycle (tx=1) between frames. Line high time between frames is CLK_DIV+1 cycles.
- Input stability:
  - valid while busy is ignored, and no word is lost: the source keeps valid high until it sees ready.
  - data changes after accept do not affect the frame in flight.
- Reset mid-frame: the frame is abandoned. From the cycle after reset is sampled, outputs take their reset values and tx returns high. No partial stop bit.
- Simultaneous reset and valid: reset wins; no accept.
- Counter widths: baud counter is clog2(CLK_DIV) bits; bit counter is clog2(WIDTH+1) bits. Counters wrap only via explicit clear; they never overflow.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- When defined:
  - PARITY state is inserted between DATA and STOP, lasting CLK_DIV cycles.
  - tx = XOR of the latched word XOR PARITY_ODD.
  - Parity is computed at accept, from the latched value.
  - Frame length is (WIDTH+3)*CLK_DIV.
- When undefined: no PARITY state, PARITY_ODD has no effect, and the frame is (WIDTH+2)*CLK_DIV.

Test Plan (WIDTH=8, CLK_DIV=4):
- Reset, then idle 20 cycles -> tx=1, ready=1, busy=0 throughout.
- Single frame: data=0x99, valid pulse 1 cycle -> tx drives 0,1,0,0,1,1,0,0,1,1, each for 4 cycles. ready=0 and busy=1 for 40 cycles, then ready=1.
- Back-to-back: valid held high with 0x99, then 0x61 presented on ready -> second frame is 0,1,0,0,0,0,1,1,0,1. Exactly 1 cycle of tx=1 separates the first stop bit from the second start bit.
- Ignore-while-busy: accept 0x99, then pulse valid with 0xFF mid-frame (cycle 12) -> frame bits unchanged, no second frame started.
- Reset mid-frame: assert reset for 1 cycle at cycle 18 of a 0x99 frame -> next cycle tx=1, ready=1, busy=0. A new 0x61 accept afterwards produces a clean full frame.
- With UART_TX_PARITY_EN and PARITY_ODD=0:
  - 0x99 -> parity bit 0, 44-cycle frame.
  - 0x61 -> parity bit 1.
  - With PARITY_ODD=1, 0x61 -> parity bit 0.

Source files
------------

// File: rtl/uart_tx_ctrl.sv
// UART transmit sequencer: accepts a word on valid/ready and serialises it as start, data LSB-first, stop.
// Define UART_TX_PARITY_EN to insert a parity bit (sense set by PARITY_ODD) between data and stop.
module uart_tx_ctrl #(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned CLK_DIV    = 4,
    parameter int unsigned PARITY_ODD = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] data,
    input  logic             valid,
    output logic             ready,
    output logic             tx,
    output logic             busy
);

    localparam int unsigned BAUD_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned BIT_W  = $clog2(WIDTH + 1);

    if (CLK_DIV < 2 || CLK_DIV > 65535 || PARITY_ODD > 1) begin : g_bad_param
        $error("uart_tx_ctrl: CLK_DIV must be 2..65535 and PARITY_ODD 0 or 1");
    end

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_TX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [BAUD_W-1:0]  baud_cnt;
    logic [BIT_W-1:0]   bit_cnt;
    logic [WIDTH-1:0]   shreg;
    logic               baud_end;
    logic               last_bit;
`ifdef UART_TX_PARITY_EN
    logic               parity_bit;
`endif

    assign baud_end = (baud_cnt == BAUD_W'(CLK_DIV - 1));
    assign last_bit = (bit_cnt == BIT_W'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
`ifdef UART_TX_PARITY_EN
            parity_bit <= 1'b0;
`endif
        end else if (state == IDLE) begin
            if (valid) begin
                shreg    <= data;
                baud_cnt <= '0;
                bit_cnt  <= '0;
`ifdef UART_TX_PARITY_EN
                parity_bit <= (^data) ^ 1'(PARITY_ODD);
`endif
            end
        end else begin
            if (baud_end) begin
                baud_cnt <= '0;
            end else begin
                baud_cnt <= baud_cnt + 1'b1;
            end
            // Shift and count only at the end of each data bit period.
            if (state == DATA && baud_end) begin
                shreg   <= shreg >> 1;
                bit_cnt <= last_bit ? '0 : bit_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (valid) state_next = START;
            START:   if (baud_end) state_next = DATA;
            DATA: begin
                if (baud_end && last_bit) begin
`ifdef UART_TX_PARITY_EN
                    state_next = PARITY;
`else
                    state_next = STOP;
`endif
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY:  if (baud_end) state_next = STOP;
`endif
            STOP:    if (baud_end) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        tx    = 1'b1;
        ready = 1'b0;
        busy  = 1'b1;
        case (state)
            IDLE: begin
                ready = 1'b1;
                busy  = 1'b0;
            end
            START:   tx = 1'b0;
            DATA:    tx = shreg[0];
`ifdef UART_TX_PARITY_EN
            PARITY:  tx = parity_bit;
`endif
            STOP:    tx = 1'b1;
            default: begin
                tx    = 1'b1;
                ready = 1'b0;
                busy  = 1'b0;
            end
        endcase
    end

endmodule
